// File: rtl/dataport_axi_if.sv
// AXI4 bus bundle between the RV32I data port (master) and the interconnect (slave).
interface dataport_axi_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Write address channel
  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWLOCK;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic [3:0]            AWQOS;
  logic                  AWUSER;
  logic                  AWVALID;
  logic                  AWREADY;

  // Write data channel
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WUSER;
  logic                  WVALID;
  logic                  WREADY;

  // Write response channel
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BUSER;
  logic                  BVALID;
  logic                  BREADY;

  // Read address channel
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;
  logic                  ARUSER;
  logic                  ARVALID;
  logic                  ARREADY;

  // Read data channel
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RUSER;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WUSER, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WUSER, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/dataport_axi.sv
// RV32I data-side AXI4 master: posted stores through a write buffer, loads ordered
// behind all buffered stores, one outstanding transaction per direction.
// Optional feature macro: DATAPORT_ERR_EN enables the sticky ERR flag from BRESP/RRESP.
module dataport_axi #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-1:0]   WRADDR,
  input  logic [DATA_WIDTH-1:0]   WRDATA,
  input  logic [DATA_WIDTH/8-1:0] WRSTRB,
  input  logic                    WREN,
  input  logic [ADDR_WIDTH-1:0]   RDADDR,
  input  logic                    RDEN,
  output logic [ADDR_WIDTH-1:0]   ORDADDR,
  output logic [DATA_WIDTH-1:0]   RDOUT,
  output logic                    RDVALID,
  output logic                    LOADING,
  output logic                    ERR,
  dataport_axi_if.master          m_axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
  } wbuf_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ADDR, R_DATA} rstate_e;

  // ---------------------------------------------------------------------------
  // Write buffer
  // ---------------------------------------------------------------------------
  wbuf_entry_t      wbuf_q [WBUF_DEPTH];
  wbuf_entry_t      push_entry;
  wbuf_entry_t      head_entry;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  wstate_e          wstate_q;
  rstate_e          rstate_q;

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Full is taken before any same-cycle pop, so a push at full is always dropped
  assign push = WREN && !full;
  assign pop  = (wstate_q == W_IDLE) && !empty;

  assign push_entry = '{addr: WRADDR, data: WRDATA, strb: WRSTRB};
  assign head_entry = wbuf_q[rd_ptr_q[PTR_W-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;

  // Buffer storage; contents need no reset since the pointers gate every read
  always_ff @(posedge CLK) begin
    if (push) begin
      wbuf_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end
  end

  // Buffer pointers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: drains one buffered store at a time as a single-beat AXI write
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  assign aw_hs = awvalid_q && m_axi.AWREADY;
  assign w_hs  = wvalid_q  && m_axi.WREADY;
  assign b_hs  = bready_q  && m_axi.BVALID;

  // AW and W retire independently; the response phase starts once both are done
  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate_q  <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (pop) begin
            awaddr_q  <= head_entry.addr;
            wdata_q   <= head_entry.data;
            wstrb_q   <= head_entry.strb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wlast_q   <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
          end
          if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
            bready_q <= 1'b1;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: one load at a time, issued only once no store is pending anywhere
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] ordaddr_q;
  logic [DATA_WIDTH-1:0] rdout_q;
  logic                  rdvalid_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  stores_drained;
  logic                  r_hs;

  // A same-cycle WREN is a store that precedes this load, so it also blocks issue
  assign stores_drained = empty && (wstate_q == W_IDLE) && !WREN;
  assign r_hs           = rready_q && m_axi.RVALID;

  // Idle loads with nothing pending skip R_WAIT so ARVALID follows RDEN by one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      ordaddr_q <= '0;
      rdout_q   <= '0;
      rdvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      rdvalid_q <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          if (RDEN) begin
            raddr_q <= RDADDR;
            if (stores_drained) begin
              arvalid_q <= 1'b1;
              rstate_q  <= R_ADDR;
            end else begin
              rstate_q  <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (stores_drained) begin
            arvalid_q <= 1'b1;
            rstate_q  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            rready_q  <= 1'b0;
            rdout_q   <= m_axi.RDATA;
            ordaddr_q <= raddr_q;
            rdvalid_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky bus-error flag
  // ---------------------------------------------------------------------------
`ifdef DATAPORT_ERR_EN
  logic err_q;

  // Any SLVERR/DECERR response latches ERR until reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if ((b_hs && m_axi.BRESP[1]) || (r_hs && m_axi.RRESP[1])) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Core-side status; both terms are decoded straight from flops
  assign LOADING = (rstate_q != R_IDLE) || full;
  assign ORDADDR = ordaddr_q;
  assign RDOUT   = rdout_q;
  assign RDVALID = rdvalid_q;

  // Write address channel
  assign m_axi.AWID    = ID_WIDTH'(0);
  assign m_axi.AWADDR  = awaddr_q;
  assign m_axi.AWLEN   = 8'd0;
  assign m_axi.AWSIZE  = 3'b010;
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWLOCK  = 1'b0;
  assign m_axi.AWCACHE = 4'b0011;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWQOS   = 4'b0000;
  assign m_axi.AWUSER  = 1'b0;
  assign m_axi.AWVALID = awvalid_q;

  // Write data and response channels
  assign m_axi.WDATA  = wdata_q;
  assign m_axi.WSTRB  = wstrb_q;
  assign m_axi.WLAST  = wlast_q;
  assign m_axi.WUSER  = 1'b0;
  assign m_axi.WVALID = wvalid_q;
  assign m_axi.BREADY = bready_q;

  // Read address channel
  assign m_axi.ARID    = ID_WIDTH'(0);
  assign m_axi.ARADDR  = raddr_q;
  assign m_axi.ARLEN   = 8'd0;
  assign m_axi.ARSIZE  = 3'b010;
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARLOCK  = 1'b0;
  assign m_axi.ARCACHE = 4'b0011;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARQOS   = 4'b0000;
  assign m_axi.ARUSER  = 1'b0;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;

  // Response fields with no function in a single-ID, single-beat master
  logic unused_inputs;
  assign unused_inputs = ^{m_axi.BID, m_axi.BUSER, m_axi.BRESP,
                           m_axi.RID, m_axi.RLAST, m_axi.RUSER, m_axi.RRESP};

endmodule

// File: tb/tb_dataport_axi.sv
// Directed bench for dataport_axi: stores, buffer fill, handshake skew, load ordering,
// bus errors and reset mid-read.
module tb_dataport_axi;

  logic        CLK;
  logic        RST;
  logic [31:0] WRADDR;
  logic [31:0] WRDATA;
  logic [3:0]  WRSTRB;
  logic        WREN;
  logic [31:0] RDADDR;
  logic        RDEN;
  logic [31:0] ORDADDR;
  logic [31:0] RDOUT;
  logic        RDVALID;
  logic        LOADING;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

`ifdef DATAPORT_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  dataport_axi_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  dataport_axi #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .WBUF_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .WRADDR(WRADDR), .WRDATA(WRDATA), .WRSTRB(WRSTRB), .WREN(WREN),
    .RDADDR(RDADDR), .RDEN(RDEN),
    .ORDADDR(ORDADDR), .RDOUT(RDOUT), .RDVALID(RDVALID), .LOADING(LOADING), .ERR(ERR),
    .m_axi(axi)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Handshake monitor
  int          aw_hs_cnt = 0;
  int          w_hs_cnt  = 0;
  logic [31:0] aw_log[$];
  always @(posedge CLK) begin
    if (!RST) begin
      if (axi.AWVALID && axi.AWREADY) begin
        aw_hs_cnt++;
        aw_log.push_back(axi.AWADDR);
      end
      if (axi.WVALID && axi.WREADY) w_hs_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; WREN = 1'b1; RDEN = 1'b1; WRADDR = 32'h55; RDADDR = 32'h66;
    tick(); tick();
    WREN = 1'b0; RDEN = 1'b0;
    checks++; if (axi.AWVALID !== 1'b0) begin failures++; $display("FAIL rst_awvalid got %b want 0", axi.AWVALID); end
    checks++; if (axi.WVALID !== 1'b0) begin failures++; $display("FAIL rst_wvalid got %b want 0", axi.WVALID); end
    checks++; if (axi.WLAST !== 1'b0) begin failures++; $display("FAIL rst_wlast got %b want 0", axi.WLAST); end
    checks++; if (axi.BREADY !== 1'b0) begin failures++; $display("FAIL rst_bready got %b want 0", axi.BREADY); end
    checks++; if (axi.ARVALID !== 1'b0) begin failures++; $display("FAIL rst_arvalid got %b want 0", axi.ARVALID); end
    checks++; if (axi.RREADY !== 1'b0) begin failures++; $display("FAIL rst_rready got %b want 0", axi.RREADY); end
    checks++; if (RDVALID !== 1'b0) begin failures++; $display("FAIL rst_rdvalid got %b want 0", RDVALID); end
    checks++; if (RDOUT !== 32'h0) begin failures++; $display("FAIL rst_rdout got %h want 0", RDOUT); end
    checks++; if (ORDADDR !== 32'h0) begin failures++; $display("FAIL rst_ordaddr got %h want 0", ORDADDR); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", ERR); end
    checks++; if (LOADING !== 1'b0) begin failures++; $display("FAIL rst_loading got %b want 0", LOADING); end
    RST = 1'b0;
    tick();
    checks++; if (axi.AWVALID !== 1'b0) begin failures++; $display("FAIL post_rst_awvalid got %b want 0", axi.AWVALID); end
  endtask

  task automatic test_single_store();
    int aw0;
    aw0 = aw_hs_cnt;
    WREN = 1'b1; WRADDR = 32'h100; WRDATA = 32'hDEADBEEF; WRSTRB = 4'hF;
    tick();
    WREN = 1'b0;
    checks++; if (axi.AWVALID !== 1'b0) begin failures++; $display("FAIL st_awvalid_t1 got %b want 0", axi.AWVALID); end
    tick();
    checks++; if (axi.AWVALID !== 1'b1) begin failures++; $display("FAIL st_awvalid_t2 got %b want 1", axi.AWVALID); end
    checks++; if (axi.WVALID !== 1'b1) begin failures++; $display("FAIL st_wvalid_t2 got %b want 1", axi.WVALID); end
    checks++; if (axi.AWADDR !== 32'h100) begin failures++; $display("FAIL st_awaddr got %h want 100", axi.AWADDR); end
    checks++; if (axi.AWLEN !== 8'h0) begin failures++; $display("FAIL st_awlen got %h want 0", axi.AWLEN); end
    checks++; if (axi.AWSIZE !== 3'b010) begin failures++; $display("FAIL st_awsize got %b want 010", axi.AWSIZE); end
    checks++; if (axi.AWBURST !== 2'b01) begin failures++; $display("FAIL st_awburst got %b want 01", axi.AWBURST); end
    checks++; if (axi.AWCACHE !== 4'b0011) begin failures++; $display("FAIL st_awcache got %b want 0011", axi.AWCACHE); end
    checks++; if (axi.WDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL st_wdata got %h want deadbeef", axi.WDATA); end
    checks++; if (axi.WSTRB !== 4'hF) begin failures++; $display("FAIL st_wstrb got %h want f", axi.WSTRB); end
    checks++; if (axi.WLAST !== 1'b1) begin failures++; $display("FAIL st_wlast got %b want 1", axi.WLAST); end
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    checks++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0) begin failures++; $display("FAIL st_valids_drop got aw=%b w=%b want 0 0", axi.AWVALID, axi.WVALID); end
    checks++; if (axi.BREADY !== 1'b1) begin failures++; $display("FAIL st_bready got %b want 1", axi.BREADY); end
    tick(); tick();
    checks++; if (axi.BREADY !== 1'b1) begin failures++; $display("FAIL st_bready_hold got %b want 1", axi.BREADY); end
    axi.BVALID = 1'b1; axi.BRESP = 2'b00;
    tick();
    axi.BVALID = 1'b0;
    checks++; if (axi.BREADY !== 1'b0) begin failures++; $display("FAIL st_bready_drop got %b want 0", axi.BREADY); end
    checks++; if (aw_hs_cnt - aw0 !== 1) begin failures++; $display("FAIL st_aw_count got %0d want 1", aw_hs_cnt - aw0); end
  endtask

  task automatic test_skew(input bit aw_first);
    int   aw0, w0;
    logic exp_aw, exp_w;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    exp_aw = aw_first ? 1'b0 : 1'b1;
    exp_w  = aw_first ? 1'b1 : 1'b0;
    WREN = 1'b1; WRADDR = aw_first ? 32'h300 : 32'h340; WRDATA = 32'h0000_1111; WRSTRB = 4'h3;
    tick();
    WREN = 1'b0;
    tick();
    if (aw_first) axi.AWREADY = 1'b1; else axi.WREADY = 1'b1;
    tick();
    checks++; if (axi.AWVALID !== exp_aw || axi.WVALID !== exp_w) begin failures++; $display("FAIL skew%0d_first got aw=%b w=%b want %b %b", aw_first, axi.AWVALID, axi.WVALID, exp_aw, exp_w); end
    tick(); tick();
    checks++; if (axi.BREADY !== 1'b0) begin failures++; $display("FAIL skew%0d_no_resp got %b want 0", aw_first, axi.BREADY); end
    checks++; if (axi.AWVALID !== exp_aw || axi.WVALID !== exp_w) begin failures++; $display("FAIL skew%0d_hold got aw=%b w=%b want %b %b", aw_first, axi.AWVALID, axi.WVALID, exp_aw, exp_w); end
    if (aw_first) axi.WREADY = 1'b1; else axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    checks++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0) begin failures++; $display("FAIL skew%0d_both got aw=%b w=%b want 0 0", aw_first, axi.AWVALID, axi.WVALID); end
    checks++; if (axi.BREADY !== 1'b1) begin failures++; $display("FAIL skew%0d_resp got %b want 1", aw_first, axi.BREADY); end
    checks++; if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin failures++; $display("FAIL skew%0d_counts got aw=%0d w=%0d want 1 1", aw_first, aw_hs_cnt - aw0, w_hs_cnt - w0); end
    axi.BVALID = 1'b1;
    tick();
    axi.BVALID = 1'b0;
    checks++; if (axi.BREADY !== 1'b0) begin failures++; $display("FAIL skew%0d_bdone got %b want 0", aw_first, axi.BREADY); end
  endtask

  // One store holds the write FSM, then four more fill the buffer; a fifth is dropped
  task automatic test_buffer_full();
    logic [31:0] addrs [5];
    int          base, aw0;
    addrs[0] = 32'h3C0; addrs[1] = 32'h0; addrs[2] = 32'h4; addrs[3] = 32'h8; addrs[4] = 32'hC;
    base = aw_log.size(); aw0 = aw_hs_cnt;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      WREN = 1'b1; WRADDR = addrs[i]; WRDATA = 32'hA000_0000 + i; WRSTRB = 4'hF;
      tick();
      if (i == 3) begin
        checks++; if (LOADING !== 1'b0) begin failures++; $display("FAIL full_loading_3 got %b want 0", LOADING); end
      end
    end
    checks++; if (LOADING !== 1'b1) begin failures++; $display("FAIL full_loading_4 got %b want 1", LOADING); end
    WRADDR = 32'h10;
    tick();
    WREN = 1'b0;
    checks++; if (LOADING !== 1'b1) begin failures++; $display("FAIL full_loading_drop got %b want 1", LOADING); end
    for (int c = 0; c < 40; c++) begin
      axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = axi.BREADY; axi.BRESP = 2'b00;
      tick();
    end
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
    checks++; if (LOADING !== 1'b0) begin failures++; $display("FAIL full_loading_end got %b want 0", LOADING); end
    checks++; if (aw_hs_cnt - aw0 !== 5) begin failures++; $display("FAIL full_aw_count got %0d want 5", aw_hs_cnt - aw0); end
    if (aw_log.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (aw_log[base + i] !== addrs[i]) begin failures++; $display("FAIL full_order_%0d got %h want %h", i, aw_log[base + i], addrs[i]); end
      end
    end
  endtask

  task automatic test_load_after_store();
    WREN = 1'b1; WRADDR = 32'h200; WRDATA = 32'h12345678; WRSTRB = 4'hF;
    tick();
    WREN = 1'b0; RDEN = 1'b1; RDADDR = 32'h200;
    tick();
    RDEN = 1'b0;
    checks++; if (LOADING !== 1'b1) begin failures++; $display("FAIL las_loading got %b want 1", LOADING); end
    checks++; if (axi.ARVALID !== 1'b0) begin failures++; $display("FAIL las_ar_early0 got %b want 0", axi.ARVALID); end
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    tick();
    checks++; if (axi.ARVALID !== 1'b0) begin failures++; $display("FAIL las_ar_early1 got %b want 0", axi.ARVALID); end
    axi.BVALID = 1'b1;
    tick();
    axi.BVALID = 1'b0;
    checks++; if (axi.ARVALID !== 1'b0) begin failures++; $display("FAIL las_ar_early2 got %b want 0", axi.ARVALID); end
    tick();
    checks++; if (axi.ARVALID !== 1'b1) begin failures++; $display("FAIL las_arvalid got %b want 1", axi.ARVALID); end
    checks++; if (axi.ARADDR !== 32'h200) begin failures++; $display("FAIL las_araddr got %h want 200", axi.ARADDR); end
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    checks++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b1) begin failures++; $display("FAIL las_rdata_phase got ar=%b r=%b want 0 1", axi.ARVALID, axi.RREADY); end
    axi.RVALID = 1'b1; axi.RDATA = 32'h12345678; axi.RRESP = 2'b00;
    tick();
    axi.RVALID = 1'b0;
    checks++; if (RDVALID !== 1'b1) begin failures++; $display("FAIL las_rdvalid got %b want 1", RDVALID); end
    checks++; if (RDOUT !== 32'h12345678) begin failures++; $display("FAIL las_rdout got %h want 12345678", RDOUT); end
    checks++; if (ORDADDR !== 32'h200) begin failures++; $display("FAIL las_ordaddr got %h want 200", ORDADDR); end
    checks++; if (LOADING !== 1'b0) begin failures++; $display("FAIL las_loading_end got %b want 0", LOADING); end
    tick();
    checks++; if (RDVALID !== 1'b0) begin failures++; $display("FAIL las_rdvalid_pulse got %b want 0", RDVALID); end
  endtask

  task automatic test_load_idle();
    RDEN = 1'b1; RDADDR = 32'h400;
    tick();
    RDEN = 1'b0;
    checks++; if (axi.ARVALID !== 1'b1) begin failures++; $display("FAIL li_arvalid got %b want 1", axi.ARVALID); end
    checks++; if (axi.ARADDR !== 32'h400) begin failures++; $display("FAIL li_araddr got %h want 400", axi.ARADDR); end
    checks++; if (axi.ARLEN !== 8'h0 || axi.ARSIZE !== 3'b010) begin failures++; $display("FAIL li_arfields got len=%h size=%b want 0 010", axi.ARLEN, axi.ARSIZE); end
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    tick();
    checks++; if (RDVALID !== 1'b0 || axi.RREADY !== 1'b1) begin failures++; $display("FAIL li_wait got rdv=%b rr=%b want 0 1", RDVALID, axi.RREADY); end
    axi.RVALID = 1'b1; axi.RDATA = 32'hCAFEF00D;
    tick();
    axi.RVALID = 1'b0;
    checks++; if (RDVALID !== 1'b1 || RDOUT !== 32'hCAFEF00D || ORDADDR !== 32'h400) begin failures++; $display("FAIL li_return got v=%b d=%h a=%h want 1 cafef00d 400", RDVALID, RDOUT, ORDADDR); end
  endtask

  task automatic test_bus_error();
    WREN = 1'b1; WRADDR = 32'h700; WRDATA = 32'h1; WRSTRB = 4'h1;
    tick();
    WREN = 1'b0;
    tick();
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL be_err_before got %b want 0", ERR); end
    axi.BVALID = 1'b1; axi.BRESP = 2'b10;
    tick();
    axi.BVALID = 1'b0; axi.BRESP = 2'b00;
    checks++; if (ERR !== ERR_EXP) begin failures++; $display("FAIL be_err_set got %b want %b", ERR, ERR_EXP); end
    RDEN = 1'b1; RDADDR = 32'h704;
    tick();
    RDEN = 1'b0;
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b1; axi.RDATA = 32'h0BAD_0704; axi.RRESP = 2'b10;
    tick();
    axi.RVALID = 1'b0; axi.RRESP = 2'b00;
    checks++; if (RDVALID !== 1'b1 || RDOUT !== 32'h0BAD_0704) begin failures++; $display("FAIL be_rdata got v=%b d=%h want 1 0bad0704", RDVALID, RDOUT); end
    tick(); tick();
    checks++; if (ERR !== ERR_EXP) begin failures++; $display("FAIL be_err_hold got %b want %b", ERR, ERR_EXP); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL be_err_clear got %b want 0", ERR); end
  endtask

  task automatic test_reset_mid_read();
    RDEN = 1'b1; RDADDR = 32'h500;
    tick();
    RDEN = 1'b0;
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    checks++; if (axi.RREADY !== 1'b1) begin failures++; $display("FAIL rmr_in_rdata got %b want 1", axi.RREADY); end
    RST = 1'b1; axi.RVALID = 1'b1; axi.RDATA = 32'hBADBAD00;
    tick();
    RST = 1'b0; axi.RVALID = 1'b0;
    checks++; if (axi.RREADY !== 1'b0 || RDVALID !== 1'b0 || LOADING !== 1'b0) begin failures++; $display("FAIL rmr_after_rst got rr=%b rdv=%b ld=%b want 0 0 0", axi.RREADY, RDVALID, LOADING); end
    RDEN = 1'b1; RDADDR = 32'h600;
    tick();
    RDEN = 1'b0;
    checks++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h600) begin failures++; $display("FAIL rmr_new_ar got v=%b a=%h want 1 600", axi.ARVALID, axi.ARADDR); end
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b1; axi.RDATA = 32'h0060_0600;
    tick();
    axi.RVALID = 1'b0;
    checks++; if (RDVALID !== 1'b1 || RDOUT !== 32'h0060_0600 || ORDADDR !== 32'h600) begin failures++; $display("FAIL rmr_new_ret got v=%b d=%h a=%h want 1 00600600 600", RDVALID, RDOUT, ORDADDR); end
  endtask

  initial begin
    RST = 1'b1; WREN = 1'b0; RDEN = 1'b0;
    WRADDR = '0; WRDATA = '0; WRSTRB = '0; RDADDR = '0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
    axi.BID = '0; axi.BRESP = 2'b00; axi.BUSER = 1'b0; axi.BVALID = 1'b0;
    axi.RID = '0; axi.RDATA = '0; axi.RRESP = 2'b00; axi.RLAST = 1'b1; axi.RUSER = 1'b0; axi.RVALID = 1'b0;
    test_reset();
    test_single_store();
    test_skew(1'b1);
    test_skew(1'b0);
    test_buffer_full();
    test_load_after_store();
    test_load_idle();
    test_bus_error();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
